// File: rtl/proc_pkg.sv
// Shared opcode, ALUOp, write-back and state encodings for the 8-bit core's
// control sequencer.
package proc_pkg;

   typedef enum logic [2:0] {
      OP_LSR  = 3'b000,
      OP_XOR  = 3'b001,
      OP_BPOS = 3'b010,
      OP_BEQZ = 3'b011,
      OP_LW   = 3'b100,
      OP_SW   = 3'b101,
      OP_MOV  = 3'b110,
      OP_HALT = 3'b111
   } opcode_t;

   localparam logic [2:0] ALU_NOP = 3'b000;
   localparam logic [2:0] ALU_LSR = 3'b001;
   localparam logic [2:0] ALU_POS = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_BEQ = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6
   } state_t;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_RB  = 2'd2;

endpackage

// File: rtl/proc_ctrl_if.sv
// Datapath-facing bundle of the control sequencer: ROM, ALU, register file,
// branch LUT and data-memory handshake.
interface proc_ctrl_if #(
   parameter int PC_W  = 10,
   parameter int LUT_W = 5
);
   logic [PC_W-1:0]  instr_addr;
   logic [8:0]       instr;
   logic [2:0]       alu_op;
   logic             alu_taken;
   logic [2:0]       rf_ra;
   logic [2:0]       rf_rb;
   logic             rf_we;
   logic [1:0]       wb_sel;
   logic [LUT_W-1:0] lut_idx;
   logic [PC_W-1:0]  lut_target;
   logic             mem_req;
   logic             mem_we;
   logic             mem_ack;

   modport master (
      output instr_addr, alu_op, rf_ra, rf_rb, rf_we, wb_sel, lut_idx, mem_req, mem_we,
      input  instr, alu_taken, lut_target, mem_ack
   );

   modport slave (
      input  instr_addr, alu_op, rf_ra, rf_rb, rf_we, wb_sel, lut_idx, mem_req, mem_we,
      output instr, alu_taken, lut_target, mem_ack
   );
endinterface

// File: rtl/proc_decode.sv
// Combinational opcode decoder: ALUOp, write-back source and instruction
// class flags used by the sequencer.
module proc_decode
   import proc_pkg::*;
(
   input  opcode_t    op,
   output logic [2:0] alu_op,
   output logic [1:0] wb_sel,
   output logic       is_branch,
   output logic       is_mem,
   output logic       is_store,
   output logic       is_halt,
   output logic       is_mov
);
   always_comb begin
      alu_op    = ALU_NOP;
      wb_sel    = WB_ALU;
      is_branch = 1'b0;
      is_mem    = 1'b0;
      is_store  = 1'b0;
      is_halt   = 1'b0;
      is_mov    = 1'b0;
      case (op)
         OP_LSR:  alu_op = ALU_LSR;
         OP_XOR:  alu_op = ALU_XOR;
         OP_BPOS: begin alu_op = ALU_POS; is_branch = 1'b1; end
         OP_BEQZ: begin alu_op = ALU_BEQ; is_branch = 1'b1; end
         // Memory ops leave the ALU idle; the address comes from the register file.
         OP_LW:   begin is_mem = 1'b1; wb_sel = WB_MEM; end
         OP_SW:   begin is_mem = 1'b1; is_store = 1'b1; end
         OP_MOV:  begin is_mov = 1'b1; wb_sel = WB_RB; end
         OP_HALT: is_halt = 1'b1;
      endcase
   end
endmodule

// File: rtl/proc_ctrl.sv
// Multi-cycle control sequencer: owns pc and ir, walks
// FETCH/DECODE/EXEC/MEM/WB and counts busy cycles.
module proc_ctrl
   import proc_pkg::*;
#(
   parameter int PC_W  = 10,
   parameter int LUT_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   proc_ctrl_if.master      bus,
   output logic             done,
   output logic [CNT_W-1:0] cycle_cnt
);
   state_t           state_reg, state_next;
   logic [PC_W-1:0]  pc_reg, pc_next;
   logic [8:0]       ir_reg, ir_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   opcode_t    op;
   logic [2:0] dec_alu_op;
   logic [1:0] dec_wb_sel;
   logic       is_branch, is_mem, is_store, is_halt, is_mov;

   assign op = opcode_t'(ir_reg[8:6]);

   proc_decode u_decode (
      .op        (op),
      .alu_op    (dec_alu_op),
      .wb_sel    (dec_wb_sel),
      .is_branch (is_branch),
      .is_mem    (is_mem),
      .is_store  (is_store),
      .is_halt   (is_halt),
      .is_mov    (is_mov)
   );

   assign bus.instr_addr = pc_reg;
   assign bus.rf_ra      = ir_reg[5:3];
   assign bus.rf_rb      = ir_reg[2:0];
   assign bus.lut_idx    = ir_reg[LUT_W-1:0];
   assign cycle_cnt      = cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         pc_reg    <= '0;
         ir_reg    <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         ir_reg    <= ir_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      pc_next     = pc_reg;
      ir_next     = ir_reg;
      cnt_next    = cnt_reg;
      bus.alu_op  = ALU_NOP;
      bus.rf_we   = 1'b0;
      bus.wb_sel  = WB_ALU;
      bus.mem_req = 1'b0;
      bus.mem_we  = 1'b0;
      done        = 1'b0;

      // Busy-cycle counter sticks at all-ones instead of wrapping.
      if (state_reg != ST_IDLE && state_reg != ST_HALT && cnt_reg != '1)
         cnt_next = cnt_reg + 1'b1;

      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_FETCH;
               pc_next    = '0;
               cnt_next   = '0;
            end
         end
         ST_FETCH: begin
            ir_next    = bus.instr;
            state_next = ST_DECODE;
         end
         ST_DECODE: begin
            if (is_halt)     state_next = ST_HALT;
            else if (is_mov) state_next = ST_WB;
            else             state_next = ST_EXEC;
         end
         ST_EXEC: begin
            bus.alu_op = dec_alu_op;
            if (is_branch) begin
               pc_next    = bus.alu_taken ? bus.lut_target : pc_reg + 1'b1;
               state_next = ST_FETCH;
            end else if (is_mem) begin
               state_next = ST_MEM;
            end else begin
               state_next = ST_WB;
            end
         end
         ST_MEM: begin
            bus.mem_req = 1'b1;
            bus.mem_we  = is_store;
            if (bus.mem_ack) begin
               if (is_store) begin
                  pc_next    = pc_reg + 1'b1;
                  state_next = ST_FETCH;
               end else begin
                  state_next = ST_WB;
               end
            end
         end
         ST_WB: begin
            bus.rf_we  = 1'b1;
            bus.wb_sel = dec_wb_sel;
            pc_next    = pc_reg + 1'b1;
            state_next = ST_FETCH;
         end
         ST_HALT: begin
            done = 1'b1;
            if (start) begin
               state_next = ST_FETCH;
               pc_next    = '0;
               cnt_next   = '0;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end
endmodule

// File: tb/tb_proc_ctrl.sv
// Directed bench for proc_ctrl: ROM/LUT/memory models around the sequencer,
// expected ALU/write-back/memory events queued and checked by a monitor.
module tb_proc_ctrl;
   localparam int PC_W  = 10;
   localparam int LUT_W = 5;
   localparam int CNT_W = 16;

   localparam int EV_ALU = 1;
   localparam int EV_WB  = 2;
   localparam int EV_MEM = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             done;
   logic [CNT_W-1:0] cycle_cnt;

   proc_ctrl_if #(.PC_W(PC_W), .LUT_W(LUT_W)) bus ();

   proc_ctrl #(.PC_W(PC_W), .LUT_W(LUT_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .bus       (bus),
      .done      (done),
      .cycle_cnt (cycle_cnt)
   );

   always #5 clk = ~clk;

   logic [8:0]      rom [1024];
   logic [PC_W-1:0] lut [32];
   assign bus.instr      = rom[bus.instr_addr];
   assign bus.lut_target = lut[bus.lut_idx];

   int          n_chk  = 0;
   int          n_pass = 0;
   int          ack_n  = 1;
   int          mem_cyc = 0;
   logic        mon_en = 1'b1;
   logic [31:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
   endtask

   function automatic logic [31:0] ev(input int k, input int a, input int b, input int c);
      return {k[7:0], a[7:0], b[7:0], c[7:0]};
   endfunction

   task automatic see(input logic [31:0] got);
      if (exp_q.size() == 0) chk("unexpected_event", got, 32'h0);
      else chk("event", got, exp_q.pop_front());
   endtask

   // Memory responder: ack on the ack_n-th cycle of each request.
   initial begin
      bus.mem_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.mem_req) begin
            mem_cyc++;
            bus.mem_ack = (mem_cyc == ack_n);
         end else begin
            mem_cyc = 0;
            bus.mem_ack = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         if (bus.alu_op != 3'b000) see(ev(EV_ALU, int'(bus.alu_op), 0, 0));
         if (bus.rf_we) see(ev(EV_WB, int'(bus.wb_sel), int'(bus.rf_ra), int'(bus.rf_rb)));
         if (bus.mem_req && bus.mem_ack) see(ev(EV_MEM, int'(bus.mem_we), mem_cyc, 0));
      end
   end

   // Called at the FETCH negedge of an instruction; checks pc holds until the
   // last cycle and then moves to exp_pc. start_at pulses start mid-instruction.
   task automatic run_instr(input string name, input int n, input logic [PC_W-1:0] exp_pc,
                            input int start_at);
      logic [PC_W-1:0] p0;
      p0 = bus.instr_addr;
      for (int i = 1; i <= n; i++) begin
         if (i == start_at) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         if (i == n - 1) chk({name, "_hold"}, 32'(bus.instr_addr), 32'(p0));
      end
      chk({name, "_pc"}, 32'(bus.instr_addr), 32'(exp_pc));
      $display("txn %s: pc 0x%0h -> 0x%0h in %0d cycles", name, p0, bus.instr_addr, n);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = 9'b111_000_000;
      for (int i = 0; i < 32; i++) lut[i] = '0;
      lut[5]  = 10'h0A0;
      lut[15] = 10'h3FF;
      rom[10'h000] = 9'b001_010_011;   // XOR r2,r3
      rom[10'h001] = 9'b011_000_101;   // BEQZ lut[5]
      rom[10'h0A0] = 9'b011_000_101;   // BEQZ lut[5]
      rom[10'h0A1] = 9'b100_001_100;   // LW
      rom[10'h0A2] = 9'b101_010_001;   // SW
      rom[10'h0A3] = 9'b110_011_110;   // MOV
      rom[10'h0A4] = 9'b000_101_010;   // LSR
      rom[10'h0A5] = 9'b010_001_111;   // BPOS lut[15]
      rom[10'h3FF] = 9'b001_110_001;   // XOR r6,r1
      bus.alu_taken = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_pc", 32'(bus.instr_addr), 32'h0);
      chk("rst_alu_op", 32'(bus.alu_op), 32'h0);
      chk("rst_rf_we", 32'(bus.rf_we), 32'h0);
      chk("rst_wb_sel", 32'(bus.wb_sel), 32'h0);
      chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_cnt", 32'(cycle_cnt), 32'h0);

      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_cnt", 32'(cycle_cnt), 32'h0);
      chk("idle_done", 32'(done), 32'h0);

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_pc", 32'(bus.instr_addr), 32'h0);
      chk("start_cnt", 32'(cycle_cnt), 32'h0);

      exp_q.push_back(ev(EV_ALU, 4, 0, 0));
      exp_q.push_back(ev(EV_WB, 0, 2, 3));
      run_instr("xor", 4, 10'h001, 0);

      bus.alu_taken = 1'b1;
      exp_q.push_back(ev(EV_ALU, 5, 0, 0));
      run_instr("beqz_taken", 3, 10'h0A0, 0);

      bus.alu_taken = 1'b0;
      exp_q.push_back(ev(EV_ALU, 5, 0, 0));
      run_instr("beqz_not_taken", 3, 10'h0A1, 0);

      ack_n = 3;
      exp_q.push_back(ev(EV_MEM, 0, 3, 0));
      exp_q.push_back(ev(EV_WB, 1, 1, 4));
      run_instr("lw", 7, 10'h0A2, 4);

      ack_n = 1;
      exp_q.push_back(ev(EV_MEM, 1, 1, 0));
      run_instr("sw", 4, 10'h0A3, 0);

      exp_q.push_back(ev(EV_WB, 2, 3, 6));
      run_instr("mov", 3, 10'h0A4, 0);

      exp_q.push_back(ev(EV_ALU, 1, 0, 0));
      exp_q.push_back(ev(EV_WB, 0, 5, 2));
      run_instr("lsr", 4, 10'h0A5, 0);

      bus.alu_taken = 1'b1;
      exp_q.push_back(ev(EV_ALU, 3, 0, 0));
      run_instr("bpos", 3, 10'h3FF, 0);

      exp_q.push_back(ev(EV_ALU, 4, 0, 0));
      exp_q.push_back(ev(EV_WB, 0, 6, 1));
      run_instr("xor_wrap", 4, 10'h000, 0);

      // Asynchronous reset while the XOR at pc 0 sits in EXEC.
      rom[10'h3FF] = 9'b111_000_000;
      exp_q.push_back(ev(EV_ALU, 4, 0, 0));
      repeat (2) @(negedge clk);
      chk("exec_alu_op", 32'(bus.alu_op), 32'h4);
      #2 rst_n = 1'b0;
      #1;
      chk("async_alu_op", 32'(bus.alu_op), 32'h0);
      chk("async_cnt", 32'(cycle_cnt), 32'h0);
      chk("async_rf_we", 32'(bus.rf_we), 32'h0);
      $display("txn reset_in_exec: alu_op 0x%0h cycle_cnt %0d", bus.alu_op, cycle_cnt);

      @(negedge clk);
      rom[10'h000] = 9'b010_001_111;   // BPOS lut[15] -> 0x3FF (HALT)
      rst_n = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      exp_q.push_back(ev(EV_ALU, 3, 0, 0));
      run_instr("bpos_to_halt", 3, 10'h3FF, 0);

      repeat (2) @(negedge clk);
      chk("halt_done", 32'(done), 32'h1);
      chk("halt_pc", 32'(bus.instr_addr), 32'h3FF);
      chk("halt_cnt", 32'(cycle_cnt), 32'h5);
      repeat (5) @(negedge clk);
      chk("halt_cnt_frozen", 32'(cycle_cnt), 32'h5);
      chk("halt_done_held", 32'(done), 32'h1);
      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("txn halt: pc 0x%0h cycle_cnt %0d done %0d", bus.instr_addr, cycle_cnt, done);

      // Self-branch loop at pc 0 to drive the counter into saturation.
      rom[10'h000] = 9'b011_000_000;
      mon_en = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("restart_pc", 32'(bus.instr_addr), 32'h0);
      chk("restart_cnt", 32'(cycle_cnt), 32'h0);
      chk("restart_done", 32'(done), 32'h0);
      repeat (65540) @(negedge clk);
      chk("sat_cnt", 32'(cycle_cnt), 32'hFFFF);
      @(negedge clk);
      chk("sat_cnt_hold", 32'(cycle_cnt), 32'hFFFF);
      $display("txn saturate: cycle_cnt 0x%0h", cycle_cnt);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/proc_ctrl.md
Name: proc_ctrl

Overview:
- Multi-cycle control sequencer for the 8-bit processor core.
- Owns the program counter and instruction register, and decodes 9-bit instructions into ALUOp, register-file and data-memory controls.
- Resolves branches from the ALU `taken` flag via a branch-target LUT.
- Sits between instruction ROM, register file, ALU and data memory; it holds no datapath values itself.

Parameters:
- PC_W, 10, program counter / instruction address width.
- LUT_W, 5, branch-target LUT index width (taken from ir[4:0]).
- CNT_W, 16, cycle counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begin execution at PC=0 (sampled in IDLE or HALT only).
- instr_addr  out  PC_W  instruction ROM address (= pc).
- instr  in  9  ROM data; combinational from instr_addr.
- alu_op  out  3  ALUOp to ALU.
- alu_taken  in  1  ALU branch-condition output.
- rf_ra  out  3  register read address A (ir[5:3]).
- rf_rb  out  3  register read address B (ir[2:0]).
- rf_we  out  1  register write strobe, 1 cycle.
- wb_sel  out  2  write-back source: 0 ALU, 1 memory, 2 register B (MOV).
- lut_idx  out  LUT_W  branch-target LUT index.
- lut_target  in  PC_W  branch target from LUT.
- mem_req  out  1  data-memory request, held until ack.
- mem_we  out  1  1 = store, valid while mem_req.
- mem_ack  in  1  memory completion, 1 cycle.
- done  out  1  high in HALT.
- cycle_cnt  out  CNT_W  cycles since start, saturating.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; pc=0, ir=0, cycle_cnt=0.
  - All strobes 0 (rf_we, mem_req, mem_we, done); alu_op=000; wb_sel=0.
- Opcode ir[8:6]:
  - 000 LSR → alu_op 001.
  - 001 XOR → 100.
  - 010 BPOS → 011.
  - 011 BEQZ → 101.
  - 100 LW.
  - 101 SW.
  - 110 MOV.
  - 111 HALT.
  - alu_op=000 in every state other than EXEC.
- States:
  - IDLE: wait for start; on start go to FETCH with pc=0, cycle_cnt=0.
  - FETCH (1 cycle): ir <= instr; go to DECODE.
  - DECODE (1 cycle): rf_ra and rf_rb are valid from here on.
    - HALT → HALT state, pc unchanged.
    - MOV → WB.
    - All other opcodes → EXEC.
  - EXEC (1 cycle): alu_op is driven.
    - LSR/XOR → WB.
    - BPOS/BEQZ: pc <= alu_taken ? lut_target : pc+1; go to FETCH.
    - LW/SW → MEM; alu_op stays 000 for these.
  - MEM: mem_req=1, mem_we=(SW). Hold all mem outputs stable until the cycle mem_ack=1.
    - On ack, LW → WB.
    - On ack, SW → pc+1, go to FETCH.
    - No timeout.
  - WB (1 cycle): rf_we=1, wb_sel per opcode; pc <= pc+1; go to FETCH.
  - HALT: done=1; start → FETCH with pc=0, cycle_cnt=0.
- Latency:
  - ALU op and MOV: 4 cycles (MOV 3: FETCH, DECODE, WB).
  - Branch: 3 cycles.
  - LW: 4 + N, where N ≥ 1 is the number of MEM cycles up to and including ack.
  - SW: 3 + N.
- lut_idx = ir[LUT_W-1:0] at all times.
- pc arithmetic is modulo 2^PC_W; pc = all-ones +1 wraps to 0.
- cycle_cnt increments every cycle outside IDLE/HALT; saturates at all-ones.
- Boundary cases:
  - start outside IDLE/HALT: ignored.
  - mem_ack outside MEM: ignored.
  - mem_ack in the first MEM cycle is accepted (N=1).
  - Reset mid-MEM drops mem_req immediately (asynchronous).
  - Illegal states decode to IDLE.

Decomposition:
- Package proc_pkg holds:
  - opcode enum (OP_LSR..OP_HALT);
  - ALUOp constants (ALU_LSR=001, ALU_POS=011, ALU_XOR=100, ALU_BEQ=101, ALU_NOP=000);
  - state enum;
  - wb_sel constants.
- One sub-module, proc_decode: combinational; opcode → alu_op, wb_sel, class flags (is_branch, is_mem, is_store, is_halt, is_mov).

Test Plan:
- Reset/start: rst_n low mid-EXEC → all outputs at reset values same cycle; start pulse → instr_addr=0 next cycle, FETCH.
- XOR: ir=9'b001_010_011 → alu_op=100 only in EXEC; rf_we=1 for exactly 1 cycle in WB, wb_sel=0, ra=2, rb=3; pc 0→1 after 4 cycles.
- Branch both ways: BEQZ with lut_idx=5, lut_target=0x0A0.
  - alu_taken=1 → pc=0x0A0.
  - alu_taken=0 → pc+1.
  - Branch takes 3 cycles, rf_we never asserted.
- LW with mem_ack delayed 3 cycles: mem_req high for exactly 3 cycles, then rf_we=1, wb_sel=1.
- SW with ack in the first MEM cycle: mem_we=1, mem_req high 1 cycle, no rf_we; pc+1.
- HALT and wrap:
  - HALT at pc=0x3FF → done=1, cycle_cnt frozen; new start restarts at pc=0.
  - XOR at 0x3FF → pc wraps to 0.
  - cycle_cnt saturates at 0xFFFF after forced long run.
